spi_slave_frame: RTL and testbench

Parametrised SPI slave for the smart-home board controller: receives fixed-length command frames from the host MCU and returns a sensor status word, such as the humidity/temperature record, on MISO during the same frame. It generalises the existing fixed-format, mode-0 slave with:
- configurable frame and reply widths;
- all four SPI modes and selectable bit order;
- a frame-complete strobe and a frame-length error strobe;
- asynchronous reset.

---
 rtl/spi_slave_frame.sv | 197 +++++++++++++++++++
 tb/tb_spi_slave_frame.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_frame.sv
// ---------------------------------------------------------------------------
// spi_slave_frame
//
// Parametrised SPI slave. Receives a fixed-length command frame on MOSI and
// returns a reply word on MISO during the same frame. All SPI pins are
// asynchronous to clk and are oversampled through synchronisers. Every SPI
// event is therefore seen in the clk domain a few cycles after it happens on
// the pins.
//
// Parameters
//   FRAME_BITS : bits per received frame (8..256)
//   TX_BITS    : width of the reply word (1..FRAME_BITS)
//   CPOL       : SCK idle level
//   CPHA       : 0 = sample on the leading edge, 1 = sample on the trailing edge
//   MSB_FIRST  : 1 = MSB first on MOSI and MISO, 0 = LSB first
//
// Ports
//   clk, rst          : system clock, asynchronous active-high reset
//   sck, ssel_n, mosi : SPI pins from the master (asynchronous)
//   miso, miso_oe     : SPI data out and its pad output enable
//   tx_data           : reply word, captured when the frame starts
//   rx_data           : last complete frame, held between frames
//   rx_valid          : one-cycle pulse when rx_data has been updated
//   rx_err            : one-cycle pulse when a frame ends with a wrong bit count
//   frame_active      : high while a frame is in progress
// ---------------------------------------------------------------------------
module spi_slave_frame #(
  parameter int FRAME_BITS = 88,
  parameter int TX_BITS    = 40,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  ssel_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [TX_BITS-1:0]    tx_data,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_err,
  output logic                  frame_active
);

  // The counter must reach FRAME_BITS+1 so that an over-long frame stays
  // distinguishable from a correct one.
  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [2:0]            sck_q;
  logic [2:0]            ssel_q;
  logic [1:0]            mosi_q;
  logic [TX_BITS-1:0]    tx_shift_q;
  logic [FRAME_BITS-1:0] rx_shift_q;
  logic [FRAME_BITS-1:0] rx_data_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  first_shift_q;
  logic                  rx_valid_q;
  logic                  rx_err_q;

  // -------------------------------------------------------------------------
  // Synchronisers and edge detection
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the pre-edge value of its neighbour; this is what makes the
  // chains below behave as shift registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q  <= '0;
      ssel_q <= '0;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      ssel_q <= {ssel_q[1:0], ssel_n};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  logic sck_rise, sck_fall, lead_edge, trail_edge;
  logic sample_edge, shift_edge, ssel_fall, ssel_rise;

  assign sck_rise    = sck_q[1] & ~sck_q[2];
  assign sck_fall    = ~sck_q[1] & sck_q[2];
  assign lead_edge   = (CPOL != 0) ? sck_fall : sck_rise;
  assign trail_edge  = (CPOL != 0) ? sck_rise : sck_fall;
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
  // Resetting ssel_q to 0 means a select still held low across a reset
  // produces no falling edge, so the block waits for a fresh frame.
  assign ssel_fall   = ~ssel_q[1] & ssel_q[2];
  assign ssel_rise   = ssel_q[1] & ~ssel_q[2];

  // -------------------------------------------------------------------------
  // Frame FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Frame FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so that
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ssel_fall) state_d = ACTIVE;
      ACTIVE:  if (ssel_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Frame FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    miso         = 1'b0;
    miso_oe      = 1'b0;
    frame_active = 1'b0;
    if (state_q == ACTIVE) begin
      miso_oe      = 1'b1;
      frame_active = 1'b1;
      miso         = (MSB_FIRST != 0) ? tx_shift_q[TX_BITS-1] : tx_shift_q[0];
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: shift registers, bit counter, result and strobes
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      bit_cnt_q     <= '0;
      first_shift_q <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_err_q      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      if (state_q == IDLE) begin
        if (ssel_fall) begin
          tx_shift_q    <= tx_data;
          bit_cnt_q     <= '0;
          first_shift_q <= 1'b1;
        end
      end else if (ssel_rise) begin
        // Frame end wins over any SCK edge detected in the same cycle.
        if (bit_cnt_q == CNT_FULL) begin
          rx_data_q  <= rx_shift_q;
          rx_valid_q <= 1'b1;
        end else begin
          rx_err_q <= 1'b1;
        end
      end else begin
        if (sample_edge) begin
          rx_shift_q <= (MSB_FIRST != 0) ? {rx_shift_q[FRAME_BITS-2:0], mosi_q[1]}
                                         : {mosi_q[1], rx_shift_q[FRAME_BITS-1:1]};
          if (bit_cnt_q != CNT_SAT) begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          end
        end
        if (shift_edge) begin
          // With CPHA=1 the first bit is already on MISO from frame start,
          // so the first leading edge must not advance the register.
          if ((CPHA != 0) && first_shift_q) begin
            first_shift_q <= 1'b0;
          end else begin
            tx_shift_q <= (MSB_FIRST != 0) ? (tx_shift_q << 1) : (tx_shift_q >> 1);
          end
        end
      end
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;

endmodule

// File: tb/tb_spi_slave_frame.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_frame
//
// Drives three differently configured spi_slave_frame instances from one
// behavioural SPI master:
//   A : defaults (88-bit frame, 40-bit reply, mode 0, MSB first)
//   B : 16/16 bits, CPOL=1, CPHA=1, MSB first
//   C : 8/8 bits, mode 1, LSB first
// The master works on a polarity-neutral SCK (idle 0, leading edge = rise);
// each instance sees it inverted according to its CPOL, and only the
// selected instance sees SCK and select activity.
// Expected frame results go into a scoreboard queue when a frame is started
// and are popped when the frame-end strobe window arrives.
// ---------------------------------------------------------------------------
module tb_spi_slave_frame;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int   sel      = 0;
  logic sck_raw  = 1'b0;
  logic ssel_raw = 1'b1;
  logic mosi     = 1'b0;

  logic [39:0] tx_a = 40'hF5_5555_5555;
  logic [15:0] tx_b = 16'hA5C3;
  logic [7:0]  tx_c = 8'h01;

  logic sck_a, ssel_a, sck_b, ssel_b, sck_c, ssel_c;
  assign sck_a  = (sel == 0) ? sck_raw  : 1'b0;
  assign ssel_a = (sel == 0) ? ssel_raw : 1'b1;
  assign sck_b  = (sel == 1) ? ~sck_raw : 1'b1;
  assign ssel_b = (sel == 1) ? ssel_raw : 1'b1;
  assign sck_c  = (sel == 2) ? sck_raw  : 1'b0;
  assign ssel_c = (sel == 2) ? ssel_raw : 1'b1;

  logic        miso_a, oe_a, v_a, e_a, fa_a;
  logic [87:0] rx_a;
  logic        miso_b, oe_b, v_b, e_b, fa_b;
  logic [15:0] rx_b;
  logic        miso_c, oe_c, v_c, e_c, fa_c;
  logic [7:0]  rx_c;

  spi_slave_frame u_a (
    .clk(clk), .rst(rst), .sck(sck_a), .ssel_n(ssel_a), .mosi(mosi),
    .miso(miso_a), .miso_oe(oe_a), .tx_data(tx_a), .rx_data(rx_a),
    .rx_valid(v_a), .rx_err(e_a), .frame_active(fa_a)
  );

  spi_slave_frame #(
    .FRAME_BITS(16), .TX_BITS(16), .CPOL(1), .CPHA(1), .MSB_FIRST(1)
  ) u_b (
    .clk(clk), .rst(rst), .sck(sck_b), .ssel_n(ssel_b), .mosi(mosi),
    .miso(miso_b), .miso_oe(oe_b), .tx_data(tx_b), .rx_data(rx_b),
    .rx_valid(v_b), .rx_err(e_b), .frame_active(fa_b)
  );

  spi_slave_frame #(
    .FRAME_BITS(8), .TX_BITS(8), .CPOL(0), .CPHA(1), .MSB_FIRST(0)
  ) u_c (
    .clk(clk), .rst(rst), .sck(sck_c), .ssel_n(ssel_c), .mosi(mosi),
    .miso(miso_c), .miso_oe(oe_c), .tx_data(tx_c), .rx_data(rx_c),
    .rx_valid(v_c), .rx_err(e_c), .frame_active(fa_c)
  );

  // Outputs of the currently selected instance.
  logic         obs_miso, obs_oe, obs_v, obs_e, obs_fa;
  logic [255:0] obs_rx;
  always_comb begin
    obs_miso = miso_a; obs_oe = oe_a; obs_v = v_a; obs_e = e_a; obs_fa = fa_a;
    obs_rx   = 256'(rx_a);
    case (sel)
      1: begin
        obs_miso = miso_b; obs_oe = oe_b; obs_v = v_b; obs_e = e_b; obs_fa = fa_b;
        obs_rx   = 256'(rx_b);
      end
      2: begin
        obs_miso = miso_c; obs_oe = oe_c; obs_v = v_c; obs_e = e_c; obs_fa = fa_c;
        obs_rx   = 256'(rx_c);
      end
      default: ;
    endcase
  end

  typedef enum logic [1:0] { EXP_VALID, EXP_ERR, EXP_NONE } kind_e;
  typedef struct {
    kind_e        kind;
    logic [255:0] data;
  } exp_t;

  exp_t         sb[$];
  logic [255:0] last_rx[3];
  int           n_assert = 0;
  int           n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // i-th bit on the wire for a word of the given width; zero past the end.
  function automatic logic bit_of(input logic [255:0] w, input int width, input int i,
                                  input bit msb);
    if (i >= width) return 1'b0;
    return msb ? w[width-1-i] : w[i];
  endfunction

  // One master transaction. abort_at >= 0 pulses rst after that many bits.
  task automatic run_frame(input string tag, input int nbits, input int fbits,
                           input logic [255:0] word, input bit msb, input bit cpha,
                           input logic [255:0] txw, input int txbits,
                           input int abort_at, output logic [255:0] got);
    exp_t         e;
    logic [255:0] exp_s;
    int           n;
    got   = '0;
    exp_s = '0;
    n     = (abort_at >= 0) ? abort_at : nbits;

    if (abort_at >= 0) begin
      e.kind = EXP_NONE;  e.data = '0;
    end else if (nbits == fbits) begin
      e.kind = EXP_VALID; e.data = word;
    end else begin
      e.kind = EXP_ERR;   e.data = last_rx[sel];
    end
    sb.push_back(e);

    @(negedge clk);
    ssel_raw = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_fa_before_edge3"}, 256'(obs_fa), 256'(0));
    @(negedge clk);
    check({tag, "_fa_at_edge3"}, 256'(obs_fa), 256'(1));
    check({tag, "_oe_active"}, 256'(obs_oe), 256'(1));
    repeat (4) @(negedge clk);

    for (int i = 0; i < n; i++) begin
      if (!cpha) begin
        mosi = bit_of(word, fbits, i, msb);
        repeat (2) @(negedge clk);
        got[i]  = obs_miso;
        sck_raw = 1'b1;
        repeat (5) @(negedge clk);
        sck_raw = 1'b0;
        repeat (3) @(negedge clk);
      end else begin
        sck_raw = 1'b1;
        mosi    = bit_of(word, fbits, i, msb);
        repeat (5) @(negedge clk);
        got[i]  = obs_miso;
        sck_raw = 1'b0;
        repeat (5) @(negedge clk);
      end
    end

    if (abort_at >= 0) begin
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check({tag, "_rst_rx_data"}, obs_rx, 256'(0));
      check({tag, "_rst_fa"}, 256'(obs_fa), 256'(0));
      check({tag, "_rst_oe"}, 256'(obs_oe), 256'(0));
      check({tag, "_rst_miso"}, 256'(obs_miso), 256'(0));
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check({tag, "_no_restart_while_low"}, 256'(obs_fa), 256'(0));
    end else begin
      for (int i = 0; i < nbits; i++) exp_s[i] = bit_of(txw, txbits, i, msb);
      check({tag, "_miso_stream"}, got, exp_s);
    end

    repeat (5) @(negedge clk);
    ssel_raw = 1'b1;
    repeat (2) @(negedge clk);
    check({tag, "_strobe_early"}, 256'({obs_v, obs_e}), 256'(0));
    @(negedge clk);
    e = sb.pop_front();
    check({tag, "_strobe"}, 256'({obs_v, obs_e}),
          256'((e.kind == EXP_VALID) ? 2'b10 : (e.kind == EXP_ERR) ? 2'b01 : 2'b00));
    check({tag, "_rx_data"}, obs_rx, e.data);
    @(negedge clk);
    check({tag, "_strobe_after"}, 256'({obs_v, obs_e}), 256'(0));
    check({tag, "_idle_outputs"}, 256'({obs_fa, obs_oe, obs_miso}), 256'(0));

    if (e.kind == EXP_VALID) last_rx[sel] = e.data;
    if (e.kind == EXP_NONE) begin
      last_rx[0] = '0; last_rx[1] = '0; last_rx[2] = '0;
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [255:0] got;
    logic [255:0] frame88;
    logic         quiet;
    frame88 = 256'h01_2345_6789_ABCD_EF00_1122;
    last_rx[0] = '0; last_rx[1] = '0; last_rx[2] = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_rx_data", obs_rx, 256'(0));
    check("reset_strobes", 256'({obs_v, obs_e}), 256'(0));
    check("reset_fa_oe_miso", 256'({obs_fa, obs_oe, obs_miso}), 256'(0));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Mode 0, full 88-bit frame.
    sel = 0;
    run_frame("m0_full", 88, 88, frame88, 1'b1, 1'b0, 256'(tx_a), 40, -1, got);
    // Truncated and over-long frames.
    run_frame("m0_87bit", 87, 88, frame88, 1'b1, 1'b0, 256'(tx_a), 40, -1, got);
    run_frame("m0_89bit", 89, 88, frame88, 1'b1, 1'b0, 256'(tx_a), 40, -1, got);

    // CPOL=1, CPHA=1, 16-bit frame.
    sel = 1;
    run_frame("m3_16bit", 16, 16, 256'h3C5A, 1'b1, 1'b1, 256'(tx_b), 16, -1, got);
    check("m3_first_bit", 256'(got[0]), 256'(1));

    // Mode 1, LSB first, 8-bit frame.
    sel = 2;
    run_frame("m1_lsb", 8, 8, 256'h80, 1'b0, 1'b1, 256'(tx_c), 8, -1, got);
    check("m1_first_bit", 256'(got[0]), 256'(1));

    // Reset after 40 bits, then a clean frame.
    sel = 0;
    run_frame("m0_abort", 88, 88, frame88, 1'b1, 1'b0, 256'(tx_a), 40, 40, got);
    run_frame("m0_after_rst", 88, 88, frame88, 1'b1, 1'b0, 256'(tx_a), 40, -1, got);

    // SCK activity with select high must be ignored.
    quiet = 1'b0;
    for (int t = 0; t < 10; t++) begin
      sck_raw = ~sck_raw;
      repeat (5) begin
        @(negedge clk);
        quiet = quiet | obs_fa | obs_oe | obs_v | obs_e | obs_miso;
      end
    end
    check("idle_sck_ignored", 256'(quiet), 256'(0));
    check("idle_sck_rx_kept", obs_rx, last_rx[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
